// File: rtl/rx_frame_buffer_if.sv
// rx_frame_buffer_if: nibble-in / byte-out bundle for the receive frame buffer.
// master = frame source and byte sink, slave = rx_frame_buffer.
interface rx_frame_buffer_if;
  logic [3:0]  axiid;
  logic        axiiv;
  logic        cksum_done;
  logic        cksum_kill;
  logic [7:0]  axiod;
  logic        axiov;
  logic        axiol;
  logic        axior;
  logic [15:0] frames_dropped;

  modport master (
    output axiid, axiiv, cksum_done, cksum_kill, axior,
    input  axiod, axiov, axiol, frames_dropped
  );

  modport slave (
    input  axiid, axiiv, cksum_done, cksum_kill, axior,
    output axiod, axiov, axiol, frames_dropped
  );
endinterface

// File: rtl/rx_frame_buffer.sv
// rx_frame_buffer: packs an MII nibble stream into bytes, holds each frame in a
// circular buffer until the FCS verdict, strips the FCS and replays good frames.
// Ports: clk, rst (async, active-high); bus (slave): axiid/axiiv nibble input,
// cksum_done/cksum_kill verdict, axiod/axiov/axiol/axior byte output with
// backpressure, frames_dropped saturating drop counter.
module rx_frame_buffer #(
  parameter int DEPTH     = 2048,
  parameter int MIN_BYTES = 64
) (
  input  logic             clk,
  input  logic             rst,
  rx_frame_buffer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic            first_q, first_d;
  logic            par_q, par_d;
  logic [3:0]      nib_q, nib_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [4:0][7:0] hold_q, hold_d;
  logic [2:0]      hcnt_q, hcnt_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   cm_q, cm_d;
  logic [15:0]     drop_q, drop_d;

  logic [PW-1:0]   rd_q;
  logic [PW-1:0]   vis_q;
  logic            pf_v_q;
  logic [8:0]      pf_q;
  logic            ov_q;
  logic [8:0]      od_q;

  logic [8:0]      mem_q [DEPTH];

  logic            we;
  logic [8:0]      wdata;
  logic            full;
  logic            keep;
  logic            start;
  logic            do_drop;
  logic            out_rdy;
  logic            issue;

  assign full = (wr_q - rd_q) == PW'(DEPTH);

  // Commit needs room for the held last payload byte as well.
  assign keep = !bus.cksum_kill && !par_q &&
                (cnt_q >= 16'(MIN_BYTES)) &&
                !ovf_q && !full;

  // A new frame can start from IDLE or abort a frame awaiting its verdict.
  assign start = bus.axiiv && (state_q != S_RECV);

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    par_d   = par_q;
    nib_d   = nib_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    hold_d  = hold_q;
    hcnt_d  = hcnt_q;
    wr_d    = wr_q;
    cm_d    = cm_q;
    drop_d  = drop_q;
    we      = 1'b0;
    wdata   = '0;
    do_drop = 1'b0;

    unique case (state_q)
      S_IDLE: begin
      end
      S_RECV: begin
        if (!bus.axiiv) begin
          state_d = S_WAIT;
          first_d = 1'b1;
        end else if (!par_q) begin
          nib_d = bus.axiid;
          par_d = 1'b1;
        end else begin
          par_d  = 1'b0;
          hold_d = {hold_q[3:0], bus.axiid, nib_q};
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
          // Oldest held byte leaves only when a sixth byte arrives,
          // so the last payload byte and the FCS stay held back.
          if (hcnt_q != 3'd5) begin
            hcnt_d = hcnt_q + 3'd1;
          end else if (!ovf_q) begin
            if (full) begin
              ovf_d = 1'b1;
            end else begin
              we    = 1'b1;
              wdata = {1'b0, hold_q[4]};
              wr_d  = wr_q + PW'(1);
            end
          end
        end
      end
      S_WAIT: begin
        if (bus.axiiv) begin
          do_drop = 1'b1;
        end else if (first_q) begin
          // Verdict seen here may still belong to the previous frame.
          first_d = 1'b0;
        end else if (bus.cksum_done) begin
          state_d = S_IDLE;
          if (keep) begin
            we    = 1'b1;
            wdata = {1'b1, hold_q[4]};
            wr_d  = wr_q + PW'(1);
            cm_d  = wr_q + PW'(1);
          end else begin
            do_drop = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (do_drop) begin
      wr_d = cm_q;
      if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end

    if (start) begin
      state_d = S_RECV;
      nib_d   = bus.axiid;
      par_d   = 1'b1;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      hcnt_d  = '0;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      first_q <= 1'b0;
      par_q   <= 1'b0;
      nib_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      hold_q  <= '0;
      hcnt_q  <= '0;
      wr_q    <= '0;
      cm_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      par_q   <= par_d;
      nib_q   <= nib_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      hold_q  <= hold_d;
      hcnt_q  <= hcnt_d;
      wr_q    <= wr_d;
      cm_q    <= cm_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_q[AW-1:0]] <= wdata;
    end
  end

  // Reader limit is a registered copy of commit_ptr: a read in the
  // commit cycle sees the old limit, and a fresh commit reaches the
  // output register three cycles later (limit, fetch, output).
  assign out_rdy = !ov_q || bus.axior;
  assign issue   = (rd_q != vis_q) && (!pf_v_q || out_rdy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q   <= '0;
      vis_q  <= '0;
      pf_v_q <= 1'b0;
      pf_q   <= '0;
      ov_q   <= 1'b0;
      od_q   <= '0;
    end else begin
      vis_q <= cm_q;
      if (issue) begin
        rd_q   <= rd_q + PW'(1);
        pf_q   <= mem_q[rd_q[AW-1:0]];
        pf_v_q <= 1'b1;
      end else if (out_rdy) begin
        pf_v_q <= 1'b0;
      end
      if (out_rdy) begin
        ov_q <= pf_v_q;
        if (pf_v_q) begin
          od_q <= pf_q;
        end
      end
    end
  end

  assign bus.axiod          = od_q[7:0];
  assign bus.axiol          = od_q[8];
  assign bus.axiov          = ov_q;
  assign bus.frames_dropped = drop_q;

endmodule

// File: doc/rx_frame_buffer.md
# rx_frame_buffer

Receive-side frame buffer that sits beside and downstream of the nibble-stream FCS checker. It consumes the same MII-order nibble stream the checker sees, packs nibbles into bytes, and holds each frame in a circular buffer. It commits the frame only when the checker's `done` arrives with `kill` low, stripping the 4 FCS bytes, and replays committed frames as a byte stream with last-flag and ready/valid backpressure. Frames that are bad, runt, misaligned or overflowing are rewound and counted.

## Interface
- `DEPTH`, 2048: buffer entries (power of two, ≥ 64); each entry is {last, byte[7:0]}.
- `MIN_BYTES`, 64: minimum frame length including FCS; shorter frames are dropped.
- `clk` in 1: system clock.
- `rst` in 1: reset; one clock; reset is asynchronous and active-high.
- `axiid` in 4: received nibble, valid when `axiiv`.
- `axiiv` in 1: nibble valid; high continuously for a whole frame.
- `cksum_done` in 1: checker verdict valid (sticky until next `axiiv`).
- `cksum_kill` in 1: checker FCS mismatch, qualified by `cksum_done`.
- `axiod` out 8: output byte.
- `axiov` out 1: output valid.
- `axiol` out 1: last byte of frame, qualified by `axiov`.
- `axior` in 1: downstream ready.
- `frames_dropped` out 16: saturating count of dropped frames.

## Operation
- Packing: first nibble of each pair is the low half; byte = {second, first}. Nibble parity flag toggles per valid nibble.
- Holdback: 5-byte shift register. A byte is written to the buffer only when a 6th byte enters, so at frame end the holdback holds the last payload byte plus 4 FCS bytes.
- Pointers: `wr_ptr` (speculative), `commit_ptr`, `rd_ptr`; log2(DEPTH)+1 bits with a wrap bit. Full when `wr_ptr - rd_ptr == DEPTH`. A write attempt while full sets `ovf` and suppresses further writes for that frame.
- Write FSM:
  - IDLE: on `axiiv` → RECV; clear byte count, parity, `ovf`, holdback.
  - RECV: pack and write as above; byte count saturates at 16 bits. On `axiiv` low → WAIT.
  - WAIT: ignores `cksum_done` on the first WAIT cycle (stale verdict), then waits for `cksum_done`.
    - Commit if `!cksum_kill`, parity even, count ≥ `MIN_BYTES`, and `!ovf`. Commit writes the held last payload byte with last=1 (if space exists, else drop), then sets `commit_ptr` to the new `wr_ptr` → IDLE.
    - Otherwise drop: `wr_ptr` ← `commit_ptr`, `frames_dropped` +1 (saturate at 0xFFFF) → IDLE.
  - `axiiv` rising while in WAIT: drop the pending frame (count it) and enter RECV for the new frame in the same cycle.
- Read side: entries in [`rd_ptr`, `commit_ptr`) are readable. Registered output stage with one-entry prefetch supports `axior` held high for one byte per cycle. `axiod`/`axiol` are held stable while `axiov && !axior`. Uncommitted data is never presented.

## Timing
- Reset values: `axiod`=0, `axiov`=0, `axiol`=0, `frames_dropped`=0, all pointers 0, FSM IDLE. Reset takes effect immediately and discards any partial or committed frames.
- Checker verdict arrives 2 cycles after the last valid nibble. The commit/drop decision is registered in the cycle `cksum_done` is first seen in WAIT.
- Commit-to-`axiov` latency with an empty output stage: exactly 3 cycles.
- Throughput: 1 byte/cycle out with `axior`=1. Write rate ≤ 1 byte per 2 cycles, so reads and writes never conflict at the buffer port.
- Simultaneous commit and read in the same cycle is legal. The read uses the pre-commit `commit_ptr`.

## Test plan
- 64-byte frame (128 nibbles, bytes 0x00..0x3F), `cksum_done`=1 / `kill`=0 two cycles after `axiiv` falls, `axior`=1 → 60 bytes 0x00..0x3B out on consecutive cycles, `axiol` only on 0x3B, `frames_dropped`=0.
- Same frame with `kill`=1 → no `axiov` ever, `frames_dropped`=1, following good frame output intact.
- 129-nibble frame with `kill`=0 → dropped (parity); 60-byte frame with `kill`=0 → dropped (runt); `frames_dropped`=2.
- Good frame with `axior` pattern 1,0,0,1 repeating → all 60 bytes in order, `axiod` constant during every stall, no duplicates.
- `DEPTH`=64, reader stalled, two back-to-back good 64-byte frames → first committed (60 entries), second dropped (`ovf`). After draining, a third frame is delivered; `frames_dropped`=1.
- `rst` pulsed mid-RECV and again while `axiov`=1 → outputs 0 within the same cycle, nothing replayed; next good frame delivered correctly.
